aud_time_counter: RTL

AUD_TIME_COUNTER -- requirements
Module: aud_time_counter

---
 rtl/aud_time_counter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/aud_time_counter.sv
// rtl/aud_time_counter.sv - record/playback seconds counter with speed-scaled prescaler
// Optional o_state status port is enabled by defining AUD_TIME_COUNTER_STATUS_EN.
module aud_time_counter #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int MAX_SEC = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_rec,
  input  logic       i_key_play,
  input  logic       i_key_stop,
  input  logic [2:0] i_speed,
  input  logic       i_fast,
  input  logic       i_slow,
  output logic [5:0] o_record_time,
  output logic [5:0] o_play_time,
  output logic       o_rec_full,
  output logic       o_play_done
`ifdef AUD_TIME_COUNTER_STATUS_EN
  ,
  output logic [2:0] o_state
`endif
);

  // Headroom of 8 lets a fast-play step overshoot CLK_HZ-1 before the wrap subtracts.
  localparam int             PW     = $clog2(CLK_HZ + 8);
  localparam logic [PW-1:0]  LP_HZ  = PW'(CLK_HZ);
  localparam logic [5:0]     LP_MAX = 6'(MAX_SEC);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PLAY       = 3'd3,
    S_PLAY_PAUSE = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt, w_sum;
  logic [2:0]      r_sub, w_sub_nxt;
  logic [5:0]      r_record_time, w_record_nxt;
  logic [5:0]      r_play_time, w_play_nxt;
  logic            r_rec_full, r_play_done, w_rec_full, w_play_done;
  logic [3:0]      w_step;
  logic            w_adv, w_wrap, w_rec_hit, w_play_hit;
  logic            w_stop, w_rec, w_play;

  assign w_stop = i_key_stop;
  assign w_rec  = i_key_rec & ~i_key_stop;
  assign w_play = i_key_play & ~i_key_stop & ~i_key_rec;

  always_comb begin
    w_step = 4'd1;
    w_adv  = 1'b1;
    if (r_state == S_PLAY) begin
      if (i_fast)      w_step = {1'b0, i_speed} + 4'd1;
      else if (i_slow) w_adv  = (r_sub >= i_speed);
    end
    w_sum      = r_presc + PW'(w_step);
    w_wrap     = ((r_state == S_REC) || (r_state == S_PLAY)) && w_adv && (w_sum >= LP_HZ);
    w_rec_hit  = w_wrap && (r_state == S_REC) && ((r_record_time + 6'd1) >= LP_MAX);
    w_play_hit = w_wrap && (r_state == S_PLAY) && ((r_play_time + 6'd1) >= r_record_time);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rec)                                 w_state_nxt = S_REC;
          else if (w_play && (r_record_time != '0))  w_state_nxt = S_PLAY;
        end
        S_REC: begin
          if (w_rec_hit)  w_state_nxt = S_IDLE;
          else if (w_rec) w_state_nxt = S_REC_PAUSE;
        end
        S_REC_PAUSE:  if (w_rec) w_state_nxt = S_REC;
        S_PLAY: begin
          if (w_play_hit)  w_state_nxt = S_IDLE;
          else if (w_play) w_state_nxt = S_PLAY_PAUSE;
        end
        S_PLAY_PAUSE: if (w_play) w_state_nxt = S_PLAY;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_presc_nxt  = r_presc;
    w_sub_nxt    = r_sub;
    w_record_nxt = r_record_time;
    w_play_nxt   = r_play_time;
    w_rec_full   = 1'b0;
    w_play_done  = 1'b0;
    if (w_stop) begin
      w_presc_nxt = '0;
      w_sub_nxt   = '0;
      w_play_nxt  = '0;
    end else if ((r_state == S_IDLE) && w_rec) begin
      w_presc_nxt  = '0;
      w_sub_nxt    = '0;
      w_record_nxt = '0;
    end else if ((r_state == S_IDLE) && w_play && (r_record_time != '0)) begin
      w_presc_nxt = '0;
      w_sub_nxt   = '0;
      w_play_nxt  = '0;
    end else if ((r_state == S_REC) || (r_state == S_PLAY)) begin
      if ((r_state == S_PLAY) && !i_fast && i_slow)
        w_sub_nxt = w_adv ? 3'd0 : r_sub + 3'd1;
      if (w_adv)
        w_presc_nxt = w_wrap ? (w_sum - LP_HZ) : w_sum;
      if (w_wrap && (r_state == S_REC)) begin
        w_record_nxt = r_record_time + 6'd1;
        w_rec_full   = w_rec_hit;
      end else if (w_wrap) begin
        w_play_nxt  = r_play_time + 6'd1;
        w_play_done = w_play_hit;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc       <= '0;
      r_sub         <= '0;
      r_record_time <= '0;
      r_play_time   <= '0;
      r_rec_full    <= 1'b0;
      r_play_done   <= 1'b0;
    end else begin
      r_presc       <= w_presc_nxt;
      r_sub         <= w_sub_nxt;
      r_record_time <= w_record_nxt;
      r_play_time   <= w_play_nxt;
      r_rec_full    <= w_rec_full;
      r_play_done   <= w_play_done;
    end
  end

  assign o_record_time = r_record_time;
  assign o_play_time   = r_play_time;
  assign o_rec_full    = r_rec_full;
  assign o_play_done   = r_play_done;
`ifdef AUD_TIME_COUNTER_STATUS_EN
  assign o_state       = r_state;
`endif

endmodule
